// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch stage feeding decode.
//
// Holds the fetch PC, issues in-order word requests to instruction memory,
// buffers returned words in a small FIFO and hands them to decode. Redirects
// flush the FIFO and discard responses to requests issued before the redirect.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned redirect targets raise fetch_misaligned and halt fetch
//   undefined : redirect_pc[1:0] are ignored, fetch_misaligned is tied low
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr   request channel to instruction memory
//   imem_resp_valid, imem_resp_data   in-order response channel
//   instr_valid/ready, instr, instr_pc  FIFO head towards decode
//   redirect_valid, redirect_pc       fetch redirect from branch/JAL resolution
//   fetch_misaligned                  misaligned redirect flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | issuing requests while credits allow, pushing responses
// DRAIN   | discarding responses to pre-redirect requests
// HALT    | misaligned redirect seen, idle until an aligned redirect

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];

  logic          mis_target;
  logic          halt_req;
  logic [CW:0]   inflight;
  logic          credit_ok;
  logic          req_fire;
  logic          resp_ok;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic [CW-1:0] redir_keep;
  logic [31:0]   redir_target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign mis_target = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      misaligned_q <= mis_target;
    end
  end

  // a pending trap turns the end of a drain into HALT instead of FETCH
  assign halt_req         = misaligned_q;
  assign fetch_misaligned = misaligned_q;
`else
  assign mis_target       = 1'b0;
  assign halt_req         = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  // requests in flight plus buffered words never exceed the FIFO size,
  // so every response always has a free slot waiting for it
  assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok      = inflight < (CW + 1)'(FIFO_DEPTH);
  assign imem_req_valid = !rst && (state == S_FETCH) && !redirect_valid && credit_ok;
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // a response with nothing outstanding is a protocol error and is ignored
  assign resp_ok = imem_resp_valid && (outstanding != '0);
  assign push    = resp_ok && (state == S_FETCH) && !redirect_valid;

  assign fifo_nonempty = !rst && (fifo_count != '0);
  assign instr_valid   = fifo_nonempty && !redirect_valid;
  assign pop           = instr_valid && instr_ready;
  assign instr         = fifo_nonempty ? fifo_data[head] : 32'h0;
  assign instr_pc      = fifo_nonempty ? fifo_pc[head]   : 32'h0;

  // a response landing in the redirect cycle is dropped right away
  assign redir_keep   = outstanding - (resp_ok ? CW'(1) : CW'(0));
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redir_target;
      resp_pc     <= redir_target;
      head        <= '0;
      tail        <= '0;
      fifo_count  <= '0;
      outstanding <= redir_keep;
      drop_cnt    <= redir_keep;
      if (redir_keep != '0) begin
        state <= S_DRAIN;
      end else if (mis_target) begin
        state <= S_HALT;
      end else begin
        state <= S_FETCH;
      end
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
      if (push) begin
        tail    <= ptr_inc(tail);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (state == S_DRAIN) begin
        if (resp_ok) begin
          drop_cnt <= drop_cnt - 1'b1;
          if (drop_cnt == CW'(1)) begin
            state <= halt_req ? S_HALT : S_FETCH;
          end
        end else if (drop_cnt == '0) begin
          state <= halt_req ? S_HALT : S_FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[tail] <= imem_resp_data;
      fifo_pc[tail]   <= resp_pc;
    end
  end

`ifndef SYNTHESIS
  resp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic MIS_EXP = 1'b1;
`else
  localparam logic MIS_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mpc;
    logic [31:0] addr;
    int          epoch;
    int          rdy;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  mreq_t mq[$];     // memory: accepted requests awaiting response
  exp_t  sb[$];     // words expected in the DUT FIFO, oldest first
  exp_t  pend[$];   // word accepted this cycle, enters the FIFO at the edge

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int epoch = 0;
  logic [31:0] req_pc = RPC;
  logic mis    = 1'b0;
  logic halted = 1'b0;

  int p_ready = 100, p_resp = 100, p_iready = 100, p_redir = 0;
  int lat_min = 1, lat_max = 1;
  logic        rst_req = 1'b1;
  logic        redir_req = 1'b0;
  logic [31:0] redir_tgt = 32'h0;

  int first_fire = -1, first_valid = -1;
  int pop_cnt = 0;
  logic [31:0] last_pop_pc = 32'h0;
  logic [31:0] prev_fire_addr = 32'h0;
  logic saw_wrap = 1'b0;

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(3))
      0: t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
      1: t = t & 32'h0000_0FFC;
      default: ;
    endcase
    return t;
  endfunction

  function automatic bit stale_present();
    foreach (mq[i]) if (mq[i].epoch != epoch) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver + memory model + request-side reference model
  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    forever begin
      bit   resp_now;
      bit   exp_rv;
      mreq_t m;
      @(posedge clk); #1;
      cyc++;
      if (rst_req) begin
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #1;
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        mq.delete(); sb.delete(); pend.delete();
        epoch++; req_pc = RPC; mis = 1'b0; halted = 1'b0;
        first_fire = -1; first_valid = -1;
        continue;
      end
      rst = 1'b0;
      imem_req_ready = ($urandom_range(99) < p_ready);
      resp_now = (mq.size() > 0) && (mq[0].rdy <= cyc) && ($urandom_range(99) < p_resp);
      imem_resp_valid = resp_now;
      imem_resp_data  = resp_now ? hsh(mq[0].addr) : 32'h0;
      instr_ready = ($urandom_range(99) < p_iready);
      if (redir_req) begin
        redirect_valid = 1'b1; redirect_pc = redir_tgt; redir_req = 1'b0;
      end else if ($urandom_range(999) < p_redir) begin
        redirect_valid = 1'b1; redirect_pc = rand_target();
      end else begin
        redirect_valid = 1'b0; redirect_pc = 32'h0;
      end
      #1;
      exp_rv = !halted && !stale_present() && !redirect_valid && ((mq.size() + sb.size()) < DEPTH);
      chk("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
      chk("fetch_misaligned", {31'h0, fetch_misaligned}, {31'h0, mis});
      if (redirect_valid) begin
        epoch++;
        sb.delete(); pend.delete();
        req_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis    = (redirect_pc[1:0] != 2'b00);
        halted = mis;
`endif
      end
      if (resp_now) begin
        exp_t e;
        m = mq.pop_front();
        if (m.epoch == epoch) begin
          e.pc = m.mpc; e.data = hsh(m.mpc);
          pend.push_back(e);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("imem_addr", imem_addr, req_pc);
        m.mpc = req_pc; m.addr = imem_addr; m.epoch = epoch;
        m.rdy = cyc + int'($urandom_range(lat_max, lat_min));
        mq.push_back(m);
        if (imem_addr == 32'h0 && prev_fire_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
        prev_fire_addr = imem_addr;
        if (first_fire < 0) first_fire = cyc;
        req_pc = req_pc + 32'd4;
      end
    end
  end

  // monitor: pops the scoreboard whenever decode takes a word
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst) continue;
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, (sb.size() > 0) && !redirect_valid});
      if (instr_valid && first_valid < 0) first_valid = cyc;
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL pop_unexpected: got pc %h expected no word (cycle %0d)", instr_pc, cyc);
        end else begin
          e = sb.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", instr, e.data);
        end
        last_pop_pc = instr_pc;
        pop_cnt++;
      end
      while (pend.size() > 0) sb.push_back(pend.pop_front());
    end
  end

  int base_pops;

  task automatic do_redirect(input logic [31:0] t);
    @(posedge clk); #3;
    redir_tgt = t; redir_req = 1'b1;
    @(negedge clk); #1;
    base_pops = pop_cnt;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); #1;
      if (pop_cnt != base_pops) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s: got no pop expected pc %h", name, exp_pc);
    end else begin
      chk(name, last_pop_pc, exp_pc);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_req = 1'b0;
    repeat (12) @(negedge clk);
    chk("first_latency", first_valid - first_fire, 32'd2);

    p_iready = 0;
    repeat (10) @(negedge clk);
    @(posedge clk); #3;
    chk("stall_fifo_full", sb.size(), DEPTH);
    chk("stall_no_inflight", mq.size(), 32'd0);
    chk("stall_req_low", {31'h0, imem_req_valid}, 32'h0);
    p_iready = 100;
    repeat (4) @(negedge clk);

    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 50 && mq.size() != 2; i++) @(negedge clk);
    do_redirect(32'h0000_0200);
    wait_pop("redirect_first_pc", 32'h0000_0200);
    repeat (6) @(negedge clk);

    lat_min = 1; lat_max = 2;
    do_redirect(32'hFFFF_FFF4);
    repeat (20) @(negedge clk);
    chk("wrap_seen", {31'h0, saw_wrap}, 32'h1);

    do_redirect(32'h0000_0302);
    repeat (10) @(negedge clk);
    chk("misaligned_flag", {31'h0, fetch_misaligned}, {31'h0, MIS_EXP});
    do_redirect(32'h0000_0300);
    wait_pop("resume_pc", 32'h0000_0300);
    chk("misaligned_clear", {31'h0, fetch_misaligned}, 32'h0);

    p_ready = 70; p_resp = 70; p_iready = 60; p_redir = 40;
    lat_min = 1; lat_max = 4;
    repeat (3000) @(negedge clk);

    rst_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_req = 1'b0;
    repeat (1000) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
